// File: rtl/command_word_sequencer_pkg.sv
// cmd_seq_pkg: shared state encoding and decode bit positions for the command word sequencer
package cmd_seq_pkg;
    typedef enum logic [1:0] {
        CMD_READY     = 2'd0,
        CMD_WAIT_ICW2 = 2'd1,
        CMD_WAIT_ICW3 = 2'd2,
        CMD_WAIT_ICW4 = 2'd3
    } cmd_state_t;
    localparam int ICW1_SEL_BIT = 4;
    localparam int OCW3_SEL_BIT = 3;
endpackage

// File: rtl/command_word_sequencer_bus_write_detector.sv
// bus_write_detector: samples CPU write activity and emits a one-cycle commit with captured A0/data (CMD_SEQ_INPUT_SYNC_EN adds 2-flop input synchronizers)
module bus_write_detector (
    input  logic       clock,
    input  logic       reset,
    input  logic       chip_select_n,
    input  logic       write_enable_n,
    input  logic       address,
    input  logic [7:0] data_bus_in,
    output logic       write_commit,
    output logic       commit_address,
    output logic [7:0] commit_data
);
    logic cs_s, we_s, active, active_q;
`ifdef CMD_SEQ_INPUT_SYNC_EN
    logic [1:0] cs_sync, we_sync;
    // two-flop synchronizers, idling at the inactive (high) level
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            cs_sync <= 2'b11;
            we_sync <= 2'b11;
        end else begin
            cs_sync <= {cs_sync[0], chip_select_n};
            we_sync <= {we_sync[0], write_enable_n};
        end
    assign cs_s = cs_sync[1];
    assign we_s = we_sync[1];
`else
    assign cs_s = chip_select_n;
    assign we_s = write_enable_n;
`endif
    assign active = ~cs_s & ~we_s;
    // track activity, capture the bus while active, pulse commit when activity ends
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            active_q       <= 1'b0;
            write_commit   <= 1'b0;
            commit_address <= 1'b0;
            commit_data    <= 8'h00;
        end else begin
            active_q     <= active;
            write_commit <= active_q & ~active;
            if (active) begin
                commit_address <= address;
                commit_data    <= data_bus_in;
            end
        end
endmodule

// File: rtl/command_word_sequencer.sv
// command_word_sequencer: 8259A ICW/OCW write decoder, init FSM and config registers (optional CMD_SEQ_INPUT_SYNC_EN synchronizes chip_select_n/write_enable_n)
module command_word_sequencer
    import cmd_seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        chip_select_n,
    input  logic        write_enable_n,
    input  logic        address,
    input  logic [7:0]  data_bus_in,
    output logic [7:0]  internal_data_bus,
    output logic        write_initial_command_word_1,
    output logic        write_initial_command_word_2,
    output logic        write_initial_command_word_3,
    output logic        write_initial_command_word_4,
    output logic        write_operation_control_word_1,
    output logic        write_operation_control_word_2,
    output logic        write_operation_control_word_3,
    output logic [1:0]  command_state,
    output logic        init_done,
    output logic        level_or_edge_triggered_config,
    output logic        single_or_cascade_config,
    output logic        set_icw4_config,
    output logic        call_address_interval_4_or_8_config,
    output logic [10:0] interrupt_vector_address,
    output logic [7:0]  cascade_device_config,
    output logic        u8086_or_mcs80_config,
    output logic        auto_eoi_config,
    output logic        buffered_master_or_slave_config,
    output logic        buffered_mode_config,
    output logic        special_fully_nest_config,
    output logic [7:0]  interrupt_mask
);
    logic       write_commit, commit_address;
    logic [7:0] commit_data;
    cmd_state_t state, next_state;
    logic dec_icw1, dec_icw2, dec_icw3, dec_icw4, dec_ocw1, dec_ocw2, dec_ocw3, done_set;

    bus_write_detector u_detector (
        .clock          (clock),
        .reset          (reset),
        .chip_select_n  (chip_select_n),
        .write_enable_n (write_enable_n),
        .address        (address),
        .data_bus_in    (data_bus_in),
        .write_commit   (write_commit),
        .commit_address (commit_address),
        .commit_data    (commit_data)
    );

    // decode the committed write against the current state and pick the next state
    always_comb begin
        dec_icw1   = write_commit & ~commit_address & commit_data[ICW1_SEL_BIT];
        dec_ocw2   = write_commit & ~commit_address & ~commit_data[ICW1_SEL_BIT] & ~commit_data[OCW3_SEL_BIT] & (state == CMD_READY);
        dec_ocw3   = write_commit & ~commit_address & ~commit_data[ICW1_SEL_BIT] & commit_data[OCW3_SEL_BIT] & (state == CMD_READY);
        dec_ocw1   = write_commit & commit_address & (state == CMD_READY);
        dec_icw2   = write_commit & commit_address & (state == CMD_WAIT_ICW2);
        dec_icw3   = write_commit & commit_address & (state == CMD_WAIT_ICW3);
        dec_icw4   = write_commit & commit_address & (state == CMD_WAIT_ICW4);
        next_state = dec_icw1 ? CMD_WAIT_ICW2 :
                     dec_icw2 ? (!single_or_cascade_config ? CMD_WAIT_ICW3 : set_icw4_config ? CMD_WAIT_ICW4 : CMD_READY) :
                     dec_icw3 ? (set_icw4_config ? CMD_WAIT_ICW4 : CMD_READY) :
                     dec_icw4 ? CMD_READY : state;
        done_set   = (dec_icw2 | dec_icw3 | dec_icw4) & (next_state == CMD_READY);
    end

    assign command_state = state;

    // FSM state and init completion flag
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state     <= CMD_READY;
            init_done <= 1'b0;
        end else begin
            state     <= next_state;
            init_done <= dec_icw1 ? 1'b0 : done_set ? 1'b1 : init_done;
        end

    // one-cycle strobes and the data word that goes with them
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            {write_initial_command_word_1, write_initial_command_word_2, write_initial_command_word_3,
             write_initial_command_word_4, write_operation_control_word_1, write_operation_control_word_2,
             write_operation_control_word_3} <= 7'b0;
            internal_data_bus <= 8'h00;
        end else begin
            {write_initial_command_word_1, write_initial_command_word_2, write_initial_command_word_3,
             write_initial_command_word_4, write_operation_control_word_1, write_operation_control_word_2,
             write_operation_control_word_3} <= {dec_icw1, dec_icw2, dec_icw3, dec_icw4, dec_ocw1, dec_ocw2, dec_ocw3};
            if (write_commit) internal_data_bus <= commit_data;
        end

    // configuration registers loaded by ICW1-4 and OCW1
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            level_or_edge_triggered_config      <= 1'b0;
            single_or_cascade_config            <= 1'b0;
            set_icw4_config                     <= 1'b0;
            call_address_interval_4_or_8_config <= 1'b0;
            interrupt_vector_address            <= 11'h000;
            cascade_device_config               <= 8'h00;
            {special_fully_nest_config, buffered_mode_config, buffered_master_or_slave_config,
             auto_eoi_config, u8086_or_mcs80_config} <= 5'b0;
            interrupt_mask                      <= 8'h00;
        end else begin
            if (dec_icw1) begin
                level_or_edge_triggered_config      <= commit_data[3];
                call_address_interval_4_or_8_config <= commit_data[2];
                single_or_cascade_config            <= commit_data[1];
                set_icw4_config                     <= commit_data[0];
                interrupt_vector_address[2:0]       <= commit_data[7:5];
                cascade_device_config               <= 8'h00;
                {special_fully_nest_config, buffered_mode_config, buffered_master_or_slave_config,
                 auto_eoi_config, u8086_or_mcs80_config} <= 5'b0;
                interrupt_mask                      <= 8'h00;
            end
            if (dec_icw2) interrupt_vector_address[10:3] <= commit_data;
            if (dec_icw3) cascade_device_config <= commit_data;
            if (dec_icw4) {special_fully_nest_config, buffered_mode_config, buffered_master_or_slave_config,
                           auto_eoi_config, u8086_or_mcs80_config} <= commit_data[4:0];
            if (dec_ocw1) interrupt_mask <= commit_data;
        end
endmodule

// File: tb/tb_command_word_sequencer.sv
// tb_command_word_sequencer: table-driven bench with a strobe scoreboard for command_word_sequencer
module tb_command_word_sequencer;
`ifdef CMD_SEQ_INPUT_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif
    localparam logic [6:0] S_ICW1 = 7'b1000000, S_ICW2 = 7'b0100000, S_ICW3 = 7'b0010000,
                           S_ICW4 = 7'b0001000, S_OCW1 = 7'b0000100, S_OCW2 = 7'b0000010,
                           S_OCW3 = 7'b0000001, S_NONE = 7'b0000000;

    logic clock = 1'b0, reset = 1'b1, chip_select_n = 1'b1, write_enable_n = 1'b1, address = 1'b0;
    logic [7:0] data_bus_in = 8'h00;
    logic [7:0] internal_data_bus, cascade_device_config, interrupt_mask;
    logic w_icw1, w_icw2, w_icw3, w_icw4, w_ocw1, w_ocw2, w_ocw3;
    logic [1:0] command_state;
    logic init_done, level_cfg, single_cfg, ic4_cfg, adi_cfg;
    logic [10:0] vector;
    logic u8086_cfg, aeoi_cfg, buf_ms_cfg, buf_cfg, sfnm_cfg;
    logic [6:0] str;

    command_word_sequencer dut (
        .clock                               (clock),
        .reset                               (reset),
        .chip_select_n                       (chip_select_n),
        .write_enable_n                      (write_enable_n),
        .address                             (address),
        .data_bus_in                         (data_bus_in),
        .internal_data_bus                   (internal_data_bus),
        .write_initial_command_word_1        (w_icw1),
        .write_initial_command_word_2        (w_icw2),
        .write_initial_command_word_3        (w_icw3),
        .write_initial_command_word_4        (w_icw4),
        .write_operation_control_word_1      (w_ocw1),
        .write_operation_control_word_2      (w_ocw2),
        .write_operation_control_word_3      (w_ocw3),
        .command_state                       (command_state),
        .init_done                           (init_done),
        .level_or_edge_triggered_config      (level_cfg),
        .single_or_cascade_config            (single_cfg),
        .set_icw4_config                     (ic4_cfg),
        .call_address_interval_4_or_8_config (adi_cfg),
        .interrupt_vector_address            (vector),
        .cascade_device_config               (cascade_device_config),
        .u8086_or_mcs80_config               (u8086_cfg),
        .auto_eoi_config                     (aeoi_cfg),
        .buffered_master_or_slave_config     (buf_ms_cfg),
        .buffered_mode_config                (buf_cfg),
        .special_fully_nest_config           (sfnm_cfg),
        .interrupt_mask                      (interrupt_mask)
    );

    assign str = {w_icw1, w_icw2, w_icw3, w_icw4, w_ocw1, w_ocw2, w_ocw3};

    always #5 clock = ~clock;

    typedef struct { logic a; logic [7:0] d; logic [6:0] s; logic [1:0] st; } row_t;
    typedef struct { logic [6:0] s; logic [7:0] d; logic [1:0] st; int c; } exp_t;
    row_t rows[14];
    exp_t q[$];
    exp_t e;
    int tests = 0, fails = 0, cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every strobe seen must match the next expected entry, including its cycle
    always @(posedge clock) begin
        cyc++;
        #1;
        if (!reset && str != S_NONE) begin
            if (q.size() == 0) chk("unexpected_strobe", {25'd0, str}, 32'd0);
            else begin
                e = q.pop_front();
                chk("strobe", {25'd0, str}, {25'd0, e.s});
                chk("strobe_cycle", cyc, e.c);
                chk("data_bus", {24'd0, internal_data_bus}, {24'd0, e.d});
                chk("state_at_strobe", {30'd0, command_state}, {30'd0, e.st});
            end
        end
    end

    task automatic settle(input logic [1:0] st);
        repeat (6) @(negedge clock);
        chk("strobe_missing", q.size(), 0);
        q.delete();
        chk("state_after", {30'd0, command_state}, {30'd0, st});
    endtask

    task automatic wr(input logic a, input logic [7:0] d, input logic [6:0] s, input logic [1:0] st);
        @(negedge clock);
        chip_select_n = 1'b0; write_enable_n = 1'b0; address = a; data_bus_in = d;
        repeat (2) @(negedge clock);
        if (s != S_NONE) q.push_back('{s, d, st, cyc + LAT});
        write_enable_n = 1'b1; chip_select_n = 1'b1;
        settle(st);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) wr(rows[i].a, rows[i].d, rows[i].s, rows[i].st);
    endtask

    initial begin
        rows[0]  = '{1'b0, 8'h13, S_ICW1, 2'd1};
        rows[1]  = '{1'b1, 8'h20, S_ICW2, 2'd3};
        rows[2]  = '{1'b1, 8'h03, S_ICW4, 2'd0};
        rows[3]  = '{1'b0, 8'h10, S_ICW1, 2'd1};
        rows[4]  = '{1'b1, 8'h08, S_ICW2, 2'd2};
        rows[5]  = '{1'b1, 8'h04, S_ICW3, 2'd0};
        rows[6]  = '{1'b1, 8'hFB, S_OCW1, 2'd0};
        rows[7]  = '{1'b0, 8'h20, S_OCW2, 2'd0};
        rows[8]  = '{1'b0, 8'h0A, S_OCW3, 2'd0};
        rows[9]  = '{1'b0, 8'h10, S_ICW1, 2'd1};
        rows[10] = '{1'b1, 8'h08, S_ICW2, 2'd2};
        rows[11] = '{1'b0, 8'h11, S_ICW1, 2'd1};
        rows[12] = '{1'b1, 8'h30, S_ICW2, 2'd2};
        rows[13] = '{1'b1, 8'h02, S_ICW3, 2'd3};

        repeat (3) @(negedge clock);
        chk("rst_state", {30'd0, command_state}, 0);
        chk("rst_init_done", {31'd0, init_done}, 0);
        chk("rst_strobes", {25'd0, str}, 0);
        chk("rst_vector", {21'd0, vector}, 0);
        chk("rst_mask", {24'd0, interrupt_mask}, 0);
        chk("rst_bus", {24'd0, internal_data_bus}, 0);
        chk("rst_cascade", {24'd0, cascade_device_config}, 0);
        reset = 1'b0;

        run_rows(0, 2);
        chk("single_vector_hi", {24'd0, vector[10:3]}, 32'h20);
        chk("single_vector_lo", {29'd0, vector[2:0]}, 0);
        chk("single_aeoi", {31'd0, aeoi_cfg}, 1);
        chk("single_u8086", {31'd0, u8086_cfg}, 1);
        chk("single_cfg", {31'd0, single_cfg}, 1);
        chk("single_ic4", {31'd0, ic4_cfg}, 1);
        chk("single_init_done", {31'd0, init_done}, 1);

        run_rows(3, 5);
        chk("casc_cascade", {24'd0, cascade_device_config}, 32'h04);
        chk("casc_icw4_fields", {27'd0, sfnm_cfg, buf_cfg, buf_ms_cfg, aeoi_cfg, u8086_cfg}, 0);
        chk("casc_init_done", {31'd0, init_done}, 1);

        run_rows(6, 8);
        chk("ocw1_mask", {24'd0, interrupt_mask}, 32'hFB);

        run_rows(9, 10);
        chk("mid_init_done", {31'd0, init_done}, 0);
        run_rows(11, 11);
        chk("reissue_mask", {24'd0, interrupt_mask}, 0);
        chk("reissue_cascade", {24'd0, cascade_device_config}, 0);
        run_rows(12, 13);
        chk("reissue_cascade_new", {24'd0, cascade_device_config}, 32'h02);

        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("async_rst_state", {30'd0, command_state}, 0);
        chk("async_rst_init_done", {31'd0, init_done}, 0);
        chk("async_rst_strobes", {25'd0, str}, 0);
        @(negedge clock);
        reset = 1'b0;
        wr(1'b1, 8'h55, S_OCW1, 2'd0);
        chk("post_rst_mask", {24'd0, interrupt_mask}, 32'h55);

        wr(1'b0, 8'hBB, S_ICW1, 2'd1);
        wr(1'b0, 8'h60, S_NONE, 2'd1);
        wr(1'b1, 8'h40, S_ICW2, 2'd3);
        wr(1'b1, 8'h1F, S_ICW4, 2'd0);
        chk("full_vector", {21'd0, vector}, 32'h205);
        chk("full_level", {31'd0, level_cfg}, 1);
        chk("full_adi", {31'd0, adi_cfg}, 0);
        chk("full_icw4_fields", {27'd0, sfnm_cfg, buf_cfg, buf_ms_cfg, aeoi_cfg, u8086_cfg}, 32'h1F);
        chk("full_init_done", {31'd0, init_done}, 1);

        @(negedge clock);
        chip_select_n = 1'b0; write_enable_n = 1'b0; address = 1'b1; data_bus_in = 8'hA5;
        repeat (2) @(negedge clock);
        q.push_back('{S_OCW1, 8'hA5, 2'd0, cyc + LAT});
        chip_select_n = 1'b1;
        repeat (2) @(negedge clock);
        write_enable_n = 1'b1;
        settle(2'd0);
        chk("cs_early_mask", {24'd0, interrupt_mask}, 32'hA5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/command_word_sequencer.md
# command_word_sequencer

Front-end command sequencer for the 8259A-compatible interrupt controller. It samples CPU bus writes and runs the ICW1→ICW2→(ICW3)→(ICW4) initialization state machine. It decodes every write into single-cycle ICW/OCW strobes and holds the resulting configuration registers. It sits between the bus interface and `Control_Logic_2`: it drives that block's write strobes and config inputs, and it owns `command_state`.

## Interface

Parameters: none.

Ports:

- `clock` in 1: system clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `chip_select_n` in 1: active-low chip select; asynchronous to `clock`.
- `write_enable_n` in 1: active-low write strobe; asynchronous to `clock`.
- `address` in 1: A0.
- `data_bus_in` in 8: CPU write data.
- `internal_data_bus` out 8: data of the last committed write; valid while any strobe is high.
- `write_initial_command_word_1` … `_4` out 1 each: one-cycle strobes.
- `write_operation_control_word_1` … `_3` out 1 each: one-cycle strobes.
- `command_state` out 2: 0 READY, 1 WAIT_ICW2, 2 WAIT_ICW3, 3 WAIT_ICW4.
- `init_done` out 1: high once a full init sequence has completed.
- `level_or_edge_triggered_config`, `single_or_cascade_config`, `set_icw4_config`, `call_address_interval_4_or_8_config` out 1 each: ICW1 D3, D1, D0, D2.
- `interrupt_vector_address` out 11: [2:0] from ICW1 D7:5; [10:3] from ICW2.
- `cascade_device_config` out 8: ICW3.
- `u8086_or_mcs80_config`, `auto_eoi_config`, `buffered_master_or_slave_config`, `buffered_mode_config`, `special_fully_nest_config` out 1 each: ICW4 D0, D1, D2, D3, D4.
- `interrupt_mask` out 8: OCW1.

## Operation

- **Write capture.** Each cycle, register `write_active = ~chip_select_n & ~write_enable_n`. While it is high, also register `address` and `data_bus_in`. A write commits on the first sample where `write_active` is low after being high. The address and data from the last active sample are used.
- **Decode at commit.**
  - A0=0, D4=1 → ICW1.
  - A0=0, D4=0, D3=0 → OCW2.
  - A0=0, D4=0, D3=1 → OCW3.
  - A0=1 → ICW2, ICW3 or ICW4 according to state, or OCW1 in READY.
- **ICW1 (any state).**
  - Loads ICW1 fields and vector[2:0].
  - Clears `cascade_device_config`, all ICW4 fields and `interrupt_mask` to 0.
  - Drops `init_done`.
  - Next state WAIT_ICW2.
- **WAIT_ICW2.** A0=1 loads vector[10:3]. Next state WAIT_ICW3 if single=0; else WAIT_ICW4 if IC4=1; else READY.
- **WAIT_ICW3.** A0=1 loads `cascade_device_config`. Next state WAIT_ICW4 if IC4=1, else READY.
- **WAIT_ICW4.** A0=1 loads the ICW4 fields. Next state READY.
- **READY.** A0=1 gives an OCW1 strobe and loads `interrupt_mask`. OCW2/OCW3 produce strobes only; they store no state here.
- **A0=0, D4=0 outside READY.** Ignored: no strobe, no state change.
- **`init_done`.** Set on each transition into READY from a WAIT state.
- **Strobes.** At most one strobe is high per cycle. Strobes are mutually exclusive by construction.

## Timing

- **Reset values.**
  - State READY; `init_done`=0.
  - All strobes 0.
  - All config fields and `interrupt_vector_address` 0.
  - `interrupt_mask`=8'h00; `internal_data_bus`=8'h00.
- **Latency.** The commit is detected at the first rising edge that samples `write_enable_n` high. The strobe asserts for exactly one cycle starting at the next rising edge.
- **Same-edge updates.** Config registers, `command_state` and `internal_data_bus` update on the same edge the strobe rises. They are stable while the strobe is high.
- **Chip select released early.** If `chip_select_n` rises before `write_enable_n`, the commit occurs when the sample goes inactive. A0/data come from the last sample where both were low.
- **Short writes.** A write active for less than one sample window may be missed; no strobe is produced.
- **Back-to-back writes.** Successive writes each commit, provided they are separated by at least one inactive sample.
- **Reset mid-sequence.** Returns to READY with `init_done`=0. A following A0=1 write is treated as OCW1.
- **ICW1 mid-sequence.** Restarts the sequence. Fields from the interrupted sequence are discarded.

## Configuration

- **`CMD_SEQ_INPUT_SYNC_EN` defined.** `chip_select_n` and `write_enable_n` each pass through a 2-flop synchronizer before sampling. Strobe latency grows by 2 cycles. `address`/`data_bus_in` are captured in the cycle of the synchronized active sample.
- **`CMD_SEQ_INPUT_SYNC_EN` undefined.** Single sampling register only. The inputs are then required to be synchronous to `clock`.

## Structure

- **Package `cmd_seq_pkg`:**
  - State constants `CMD_READY`=2'd0, `CMD_WAIT_ICW2`=2'd1, `CMD_WAIT_ICW3`=2'd2, `CMD_WAIT_ICW4`=2'd3.
  - Decode bit positions `ICW1_SEL_BIT`=4 and `OCW3_SEL_BIT`=3.
- **Sub-module `bus_write_detector`:** owns the synchronizer (macro-dependent), the active sampling, and the data/address capture. It outputs `write_commit`, `commit_address` and `commit_data`.
- **Top level:** holds the FSM, the decode and the config registers.

## Test plan

- **Single-mode init.** ICW1=8'h13 (single, IC4), ICW2=8'h20 (A0=1), ICW4=8'h03.
  - States 1→3→0; ICW3 is skipped.
  - `interrupt_vector_address[10:3]`=8'h20; `auto_eoi_config`=1; `u8086_or_mcs80_config`=1; `init_done`=1.
- **Cascade init without ICW4.** ICW1=8'h10, ICW2=8'h08, ICW3=8'h04.
  - States 1→2→0.
  - `cascade_device_config`=8'h04; ICW4 fields remain 0.
- **OCW traffic after init.**
  - A0=1, data 8'hFB → OCW1 strobe and `interrupt_mask`=8'hFB.
  - A0=0, 8'h20 → OCW2 strobe.
  - A0=0, 8'h0A → OCW3 strobe.
  - Each strobe is exactly one cycle at commit+1 (commit+3 with the macro).
- **ICW1 re-issued in WAIT_ICW3.**
  - State returns to 1; mask and cascade config are cleared.
  - The next A0=1 write is taken as ICW2.
- **Async reset asserted in WAIT_ICW4.**
  - Immediately: `command_state`=0, strobes 0, `init_done`=0.
  - A subsequent A0=1 write of 8'h55 produces an OCW1 strobe.
- **OCW2 write (A0=0, 8'h60) in WAIT_ICW2.** No strobe; state remains 1.
